quad_enc_decoder: RTL and testbench

QUAD_ENC_DECODER -- requirements
Module: quad_enc_decoder

---
 rtl/quad_enc_decoder.sv | 134 +++++++++++++
 tb/tb_quad_enc_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_enc_decoder.sv
// quad_enc_decoder: debounced quadrature decoder with saturating position.
// Define ENC_SWITCH_EN to include the push-switch debouncer and sw_press.
module quad_enc_decoder #(
    parameter int DEB_CYCLES  = 50000,
    parameter int POS_MAX     = 36,
    parameter int POS_DEFAULT = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       enc_sw,
    output logic       cw,
    output logic       ccw,
    output logic [5:0] pos,
    output logic       sw_press,
    output logic       err
);

`ifdef ENC_SWITCH_EN
    localparam int N = 3;
    logic [N-1:0] raw;
    assign raw = {enc_sw, enc_a, enc_b};
`else
    localparam int N = 2;
    logic [N-1:0] raw;
    assign raw = {enc_a, enc_b};
`endif

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [5:0] P_MAX = 6'(POS_MAX);
    localparam logic [5:0] P_DEF = 6'(POS_DEFAULT);

    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [N-1:0]     filt;
    logic [CNT_W-1:0] cnt [N];

    logic [1:0]        ab;
    logic [1:0]        ab_prev;
    logic [1:0]        ph_new;
    logic [1:0]        ph_old;
    logic [1:0]        delta;
    logic signed [2:0] acc;
    logic signed [3:0] sum;
    logic              changed;
    logic              illegal;
    logic              cw_d;
    logic              ccw_d;
    logic              sw_edge;

    // Quadrature phase: 11->0, 10->1, 00->2, 01->3 (CW increases)
    always_comb begin
        ab      = filt[1:0];
        ph_new  = {~ab[1], ab[1] ^ ab[0]};
        ph_old  = {~ab_prev[1], ab_prev[1] ^ ab_prev[0]};
        delta   = ph_new - ph_old;
        changed = (ab != ab_prev);
        illegal = ((ab ^ ab_prev) == 2'b11);
        sum     = {acc[2], acc};
        case (delta)
            2'd1:    sum = {acc[2], acc} + 4'sd1;
            2'd3:    sum = {acc[2], acc} - 4'sd1;
            default: sum = {acc[2], acc};
        endcase
        cw_d  = changed && !illegal && (ab == 2'b11) && (sum == 4'sd4);
        ccw_d = changed && !illegal && (ab == 2'b11) && (sum == -4'sd4);
    end

`ifdef ENC_SWITCH_EN
    logic sw_prev;
    assign sw_edge = sw_prev & ~filt[2];
`else
    assign sw_edge = 1'b0 & enc_sw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '1;
            sync2    <= '1;
            filt     <= '1;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            ab_prev  <= 2'b11;
            acc      <= '0;
            pos      <= P_DEF;
            cw       <= 1'b0;
            ccw      <= 1'b0;
            err      <= 1'b0;
            sw_press <= 1'b0;
`ifdef ENC_SWITCH_EN
            sw_prev  <= 1'b1;
`endif
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end

            ab_prev  <= ab;
            cw       <= cw_d;
            ccw      <= ccw_d;
            err      <= illegal;
            sw_press <= sw_edge;
`ifdef ENC_SWITCH_EN
            sw_prev  <= filt[2];
`endif

            if (illegal) begin
                acc <= '0;
            end else if (changed) begin
                acc <= (ab == 2'b11) ? 3'sd0 : sum[2:0];
            end

            // Switch load wins over a concurrent detent step
            if (sw_edge) begin
                pos <= P_DEF;
            end else if (cw_d && pos < P_MAX) begin
                pos <= pos + 6'd1;
            end else if (ccw_d && pos != 6'd0) begin
                pos <= pos - 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_quad_enc_decoder.sv
// tb_quad_enc_decoder: directed and randomized checks of quad_enc_decoder
// against a quarter-step position model, with DEB_CYCLES=4.
module tb_quad_enc_decoder;

    localparam int DEB = 4;
    localparam int PMAX = 36;
    localparam int PDEF = 18;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enc_a = 1'b1;
    logic       enc_b = 1'b1;
    logic       enc_sw = 1'b1;
    logic       cw;
    logic       ccw;
    logic [5:0] pos;
    logic       sw_press;
    logic       err;

    int n_checks = 0;
    int n_fail = 0;
    int n_cw = 0;
    int n_ccw = 0;
    int n_err = 0;
    int n_sw = 0;
    int pos_prev = PDEF;

    quad_enc_decoder #(
        .DEB_CYCLES(DEB),
        .POS_MAX(PMAX),
        .POS_DEFAULT(PDEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .enc_sw(enc_sw),
        .cw(cw),
        .ccw(ccw),
        .pos(pos),
        .sw_press(sw_press),
        .err(err)
    );

    always #5 clk = ~clk;

    // Per-cycle monitor: pulse counting, exclusivity, pos step rule
    always @(negedge clk) begin
        int exp;
        if (!rst) begin
            n_checks++;
            if (cw && ccw) begin
                n_fail++;
                $display("FAIL cw_ccw_exclusive: cw=%0b ccw=%0b want not both", cw, ccw);
            end
            exp = pos_prev;
            if (sw_press) exp = PDEF;
            else if (cw) exp = (pos_prev >= PMAX) ? PMAX : pos_prev + 1;
            else if (ccw) exp = (pos_prev == 0) ? 0 : pos_prev - 1;
            n_checks++;
            if (int'(pos) !== exp) begin
                n_fail++;
                $display("FAIL pos_step: pos=%0d want %0d (t=%0t)", pos, exp, $time);
            end
            if (cw) n_cw++;
            if (ccw) n_ccw++;
            if (err) n_err++;
            if (sw_press) n_sw++;
        end
        pos_prev = int'(pos);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_ab(input logic [1:0] v, input int h);
        enc_a = v[1];
        enc_b = v[0];
        tick(h);
    endtask

    task automatic cw_detent(input int h);
        drive_ab(2'b10, h);
        drive_ab(2'b00, h);
        drive_ab(2'b01, h);
        drive_ab(2'b11, h);
    endtask

    task automatic ccw_detent(input int h);
        drive_ab(2'b01, h);
        drive_ab(2'b00, h);
        drive_ab(2'b10, h);
        drive_ab(2'b11, h);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        enc_sw = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        check("reset_pos", int'(pos), PDEF);
        check("reset_cw", int'(cw), 0);
        check("reset_ccw", int'(ccw), 0);
        check("reset_err", int'(err), 0);
        check("reset_sw_press", int'(sw_press), 0);
        tick(1);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_cw_detent();
        int b_cw = n_cw, b_ccw = n_ccw, b_err = n_err;
        cw_detent(10);
        tick(10);
        check("cw_detent_cw", n_cw - b_cw, 1);
        check("cw_detent_ccw", n_ccw - b_ccw, 0);
        check("cw_detent_err", n_err - b_err, 0);
        check("cw_detent_pos", int'(pos), PDEF + 1);
    endtask

    task automatic test_saturation();
        int b_cw, b_ccw;
        apply_reset();
        b_cw = n_cw;
        for (int i = 0; i < 20; i++) cw_detent(8);
        tick(10);
        check("sat_cw_count", n_cw - b_cw, 20);
        check("sat_pos_max", int'(pos), PMAX);
        b_ccw = n_ccw;
        for (int i = 0; i < 40; i++) ccw_detent(8);
        tick(10);
        check("sat_ccw_count", n_ccw - b_ccw, 40);
        check("sat_pos_min", int'(pos), 0);
    endtask

    task automatic test_bounce();
        int b_cw, b_ccw, b_err;
        apply_reset();
        b_cw = n_cw; b_ccw = n_ccw; b_err = n_err;
        for (int i = 0; i < 15; i++) begin
            enc_a = ~enc_a;
            tick(2);
        end
        enc_a = 1'b1;
        tick(15);
        check("bounce_cw", n_cw - b_cw, 0);
        check("bounce_ccw", n_ccw - b_ccw, 0);
        check("bounce_err", n_err - b_err, 0);
        check("bounce_pos", int'(pos), PDEF);
    endtask

    task automatic test_partial();
        int b_cw, b_ccw, b_err, p0;
        apply_reset();
        b_cw = n_cw; b_ccw = n_ccw; b_err = n_err; p0 = int'(pos);
        drive_ab(2'b10, 10);
        drive_ab(2'b00, 10);
        drive_ab(2'b10, 10);
        drive_ab(2'b11, 10);
        tick(10);
        check("partial_pulses", (n_cw - b_cw) + (n_ccw - b_ccw), 0);
        check("partial_err", n_err - b_err, 0);
        check("partial_pos", int'(pos), p0);
    endtask

    task automatic test_illegal();
        int b_cw, b_err, p0;
        apply_reset();
        b_cw = n_cw; b_err = n_err; p0 = int'(pos);
        drive_ab(2'b00, 20);
        check("illegal_err", n_err - b_err, 1);
        check("illegal_pos", int'(pos), p0);
        drive_ab(2'b01, 10);
        drive_ab(2'b11, 10);
        check("illegal_recover_nopulse", n_cw - b_cw, 0);
        cw_detent(10);
        tick(10);
        check("illegal_then_cw", n_cw - b_cw, 1);
        check("illegal_then_pos", int'(pos), p0 + 1);
        check("illegal_err_total", n_err - b_err, 1);
    endtask

    task automatic test_switch();
        int b_sw;
        apply_reset();
        for (int i = 0; i < 7; i++) cw_detent(8);
        tick(10);
        check("switch_pre_pos", int'(pos), 25);
        b_sw = n_sw;
        enc_sw = 1'b0;
        tick(10);
        enc_sw = 1'b1;
        tick(15);
`ifdef ENC_SWITCH_EN
        check("switch_press_count", n_sw - b_sw, 1);
        check("switch_pos", int'(pos), PDEF);
`else
        check("switch_press_count", n_sw - b_sw, 0);
        check("switch_pos", int'(pos), 25);
`endif
    endtask

    task automatic test_reset_mid();
        int b_cw, b_ccw, b_err;
        apply_reset();
        b_cw = n_cw; b_ccw = n_ccw; b_err = n_err;
        drive_ab(2'b10, 10);
        drive_ab(2'b00, 10);
        apply_reset();
        tick(12);
        check("rstmid_pulses", (n_cw - b_cw) + (n_ccw - b_ccw), 0);
        check("rstmid_err", n_err - b_err, 0);
        check("rstmid_pos", int'(pos), PDEF);
        cw_detent(10);
        tick(10);
        check("rstmid_then_cw", n_cw - b_cw, 1);
    endtask

    // Model: quarter-step position q; a detent event fires whenever q
    // lands on a multiple of 4 that is 4 away from the last detent.
    task automatic test_random();
        int q = 0, last = 0, dir = 1, ph, pm = PDEF;
        int e_cw = 0, e_ccw = 0;
        int b_cw, b_ccw, b_err;
        logic [1:0] ab_tab [4];
        ab_tab[0] = 2'b11;
        ab_tab[1] = 2'b10;
        ab_tab[2] = 2'b00;
        ab_tab[3] = 2'b01;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            b_cw = n_cw; b_ccw = n_ccw; b_err = n_err;
            e_cw = 0; e_ccw = 0;
            for (int s = 0; s < 50; s++) begin
                if ($urandom_range(0, 3) == 0) dir = -dir;
                q += dir;
                ph = ((q % 4) + 4) % 4;
                if (ph == 0) begin
                    if (q - last == 4) begin
                        e_cw++;
                        pm = (pm >= PMAX) ? PMAX : pm + 1;
                    end else if (q - last == -4) begin
                        e_ccw++;
                        pm = (pm == 0) ? 0 : pm - 1;
                    end
                    last = q;
                end
                drive_ab(ab_tab[ph], int'($urandom_range(6, 10)));
            end
            tick(12);
            check("rand_cw", n_cw - b_cw, e_cw);
            check("rand_ccw", n_ccw - b_ccw, e_ccw);
            check("rand_err", n_err - b_err, 0);
            check("rand_pos", int'(pos), pm);
        end
    endtask

    initial begin
        test_reset();
        test_cw_detent();
        test_saturation();
        test_bounce();
        test_partial();
        test_illegal();
        test_switch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
